// File: rtl/pe_dot_requant_pkg.sv
// Shared types and constants for the dot-product requantization PE.
package pe_types;

  typedef struct packed {
    int unsigned DOT_OUTPUT_WIDTH;
  } pe_cfg_t;

  localparam pe_cfg_t DEFAULT_CFG = '{DOT_OUTPUT_WIDTH: 16};

  localparam int FEATURE_WIDTH = 7;
  localparam int MAGNITUDE_MAX = (1 << (FEATURE_WIDTH - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REQUANT,
    OUT
  } pe_state_e;

endpackage

// File: rtl/pe_dot_requant_lane.sv
// One lane of requantization: |acc| rounded half away from zero, shifted,
// saturated and packed as sign-magnitude. Purely combinational.
module pe_requant_lane
  import pe_types::*;
#(
  parameter int ACC_WIDTH  = 22,
  parameter int FEAT_WIDTH = FEATURE_WIDTH,
  parameter int MAG_MAX    = MAGNITUDE_MAX
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [4:0]            shift_i,
  output logic [FEAT_WIDTH-1:0] feature_o
);

  // Wide enough that any rounding term up to 1 << 30 cannot be lost.
  localparam int SW = ((ACC_WIDTH > 32) ? ACC_WIDTH : 32) + 1;

  logic                  neg;
  logic [ACC_WIDTH-1:0]  mag;
  logic [SW-1:0]         half;
  logic [SW-1:0]         rounded;
  logic [FEAT_WIDTH-2:0] mag_sat;

  always_comb begin
    neg       = acc_i[ACC_WIDTH-1];
    mag       = neg ? (~acc_i + ACC_WIDTH'(1)) : acc_i;
    half      = (shift_i == 5'd0) ? '0 : (SW'(1) << (shift_i - 5'd1));
    rounded   = (SW'(mag) + half) >> shift_i;
    mag_sat   = (rounded > SW'(MAG_MAX)) ? (FEAT_WIDTH-1)'(MAG_MAX)
                                         : rounded[FEAT_WIDTH-2:0];
    feature_o = {neg && (rounded != '0), mag_sat};
  end

endmodule

// File: rtl/pe_dot_requant.sv
// Accumulates per-lane dot results over a frame, then requantizes each lane
// to a sign-magnitude feature; result appears two cycles after the last beat.
module pe_dot_requant
  import pe_types::*;
#(
  parameter pe_cfg_t cfg              = DEFAULT_CFG,
  parameter int      NUM_PACKED_MULTS = 2,
  parameter int      MAX_BEATS        = 64,
  parameter int      FEATURE_WIDTH    = pe_types::FEATURE_WIDTH
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic                                                    i_valid,
  input  logic                                                    i_last,
  input  logic [4:0]                                              i_shift,
  input  logic [NUM_PACKED_MULTS-1:0][cfg.DOT_OUTPUT_WIDTH-1:0]   i_result,
  output logic                                                    o_ready,
  output logic                                                    o_valid,
  input  logic                                                    i_ready,
  output logic [NUM_PACKED_MULTS-1:0][FEATURE_WIDTH-1:0]          o_feature,
  output logic                                                    o_overflow
);

  localparam int DW = int'(cfg.DOT_OUTPUT_WIDTH);
  localparam int AW = DW + $clog2(MAX_BEATS);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS);

  pe_state_e                                      state_q, state_d;
  logic [NUM_PACKED_MULTS-1:0][AW-1:0]            acc_q, acc_d;
  logic [CW-1:0]                                  cnt_q, cnt_d, cnt_inc;
  logic [4:0]                                     shift_q, shift_d;
  logic [NUM_PACKED_MULTS-1:0][FEATURE_WIDTH-1:0] feature_q, feature_d, lane_feature;
  logic                                           ovf_q, ovf_d;
  logic                                           beat, full;

  assign o_ready    = (state_q == IDLE) || (state_q == ACCUM);
  assign o_valid    = (state_q == OUT);
  assign o_feature  = feature_q;
  assign o_overflow = ovf_q;
  assign beat       = i_valid && o_ready;

  for (genvar n = 0; n < NUM_PACKED_MULTS; n++) begin : g_lane
    pe_requant_lane #(
      .ACC_WIDTH (AW),
      .FEAT_WIDTH(FEATURE_WIDTH),
      .MAG_MAX   ((1 << (FEATURE_WIDTH - 1)) - 1)
    ) u_lane (
      .acc_i    (acc_q[n]),
      .shift_i  (shift_q),
      .feature_o(lane_feature[n])
    );
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    feature_d = feature_q;
    ovf_d     = ovf_q;
    cnt_inc   = cnt_q + CW'(1);
    full      = 1'b0;
    unique case (state_q)
      IDLE: if (beat) begin
        for (int n = 0; n < NUM_PACKED_MULTS; n++) acc_d[n] = AW'($signed(i_result[n]));
        shift_d = i_shift;
        cnt_d   = CW'(1);
        full    = (MAX_BEATS == 1);
        ovf_d   = full && !i_last;
        state_d = (i_last || full) ? REQUANT : ACCUM;
      end
      ACCUM: if (beat) begin
        for (int n = 0; n < NUM_PACKED_MULTS; n++)
          acc_d[n] = acc_q[n] + AW'($signed(i_result[n]));
        cnt_d   = cnt_inc;
        full    = (cnt_inc == LAST_CNT);
        ovf_d   = full && !i_last;
        state_d = (i_last || full) ? REQUANT : ACCUM;
      end
      REQUANT: begin
        feature_d = lane_feature;
        state_d   = OUT;
      end
      OUT: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      feature_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      feature_q <= feature_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_dot_requant.sv
// Bench for pe_dot_requant: directed corner frames plus random frames
// scored against an integer-arithmetic reference.
module tb_pe_dot_requant;
  import pe_types::*;

  localparam int N    = 2;
  localparam int DW   = 12;
  localparam int MAXB = 4;
  localparam int FW   = 7;
  localparam pe_cfg_t CFG = '{DOT_OUTPUT_WIDTH: DW};

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      i_valid;
  logic                      i_last;
  logic [4:0]                i_shift;
  logic [N-1:0][DW-1:0]      i_result;
  logic                      o_ready;
  logic                      o_valid;
  logic                      i_ready;
  logic [N-1:0][FW-1:0]      o_feature;
  logic                      o_overflow;

  int total  = 0;
  int passed = 0;
  int b0[MAXB];
  int b1[MAXB];

  always #5 clock = ~clock;

  pe_dot_requant #(
    .cfg             (CFG),
    .NUM_PACKED_MULTS(N),
    .MAX_BEATS       (MAXB),
    .FEATURE_WIDTH   (FW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .i_shift   (i_shift),
    .i_result  (i_result),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_feature (o_feature),
    .o_overflow(o_overflow)
  );

  // Reference: exact frame sum -> rounded, saturated sign-magnitude code.
  function automatic int model(input longint s, input int sh);
    longint m, r;
    m = (s < 0) ? -s : s;
    r = (sh == 0) ? m : ((m + (longint'(1) << (sh - 1))) >> sh);
    if (r > 63) r = 63;
    return ((s < 0 && r != 0) ? 64 : 0) + int'(r);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_beat(input int v0, input int v1, input bit last, input int sh);
    int w;
    w           = 0;
    i_valid     = 1'b1;
    i_last      = last;
    i_shift     = 5'(sh);
    i_result[0] = DW'(v0);
    i_result[1] = DW'(v1);
    while (o_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("beat_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int nb, input int sh,
                          input bit use_last, input int hold);
    longint s0, s1;
    int     e0, e1;
    s0 = 0;
    s1 = 0;
    for (int k = 0; k < nb; k++) begin
      s0 += b0[k];
      s1 += b1[k];
    end
    e0 = model(s0, sh);
    e1 = model(s1, sh);
    for (int k = 0; k < nb; k++)
      send_beat(b0[k], b1[k], use_last && (k == nb - 1),
                (k == 0) ? sh : int'($urandom_range(0, 31)));
    chk({tag, "_lat1_valid"}, 32'(o_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_lane0"}, 32'(o_feature[0]), 32'(e0));
    chk({tag, "_lane1"}, 32'(o_feature[1]), 32'(e1));
    chk({tag, "_ovf"}, 32'(o_overflow), 32'(!use_last));
    for (int h = 0; h < hold; h++) begin
      i_valid     = 1'b1;
      i_result[0] = DW'($urandom);
      i_ready     = 1'b0;
      tick();
      chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
      chk({tag, "_hold_lane0"}, 32'(o_feature[0]), 32'(e0));
      chk({tag, "_hold_lane1"}, 32'(o_feature[1]), 32'(e1));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int nb, sh, hold;
    bit ul;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_last   = 1'b0;
    i_shift  = '0;
    i_result = '0;
    i_ready  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_feature", 32'(o_feature), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(o_ready), 32'd1);

    b0[0] = 100; b1[0] = -100;
    do_frame("single", 1, 3, 1'b1, 0);
    chk("single_lit", 32'(o_feature), 32'({7'h4D, 7'h0D}));

    b0[0] = 10;  b0[1] = 20;  b0[2] = 30;
    b1[0] = -10; b1[1] = -20; b1[2] = -30;
    do_frame("three", 3, 0, 1'b1, 0);
    chk("three_lit", 32'(o_feature), 32'({7'h7C, 7'h3C}));

    b0[0] = 1000; b1[0] = -1000;
    do_frame("sat", 1, 2, 1'b1, 0);
    chk("sat_lit", 32'(o_feature), 32'({7'h7F, 7'h3F}));

    b0[0] = -3; b1[0] = 3;
    do_frame("negzero", 1, 3, 1'b1, 0);
    chk("negzero_lit", 32'(o_feature), 32'd0);

    b0[0] = 700; b0[1] = -50; b1[0] = -1234; b1[1] = 77;
    do_frame("backpressure", 2, 4, 1'b1, 5);

    for (int k = 0; k < MAXB; k++) begin
      b0[k] = 1;
      b1[k] = 1;
    end
    do_frame("overflow", MAXB, 0, 1'b0, 0);
    chk("overflow_lit", 32'(o_feature), 32'({7'h04, 7'h04}));

    send_beat(900, -900, 1'b0, 4);
    send_beat(900, -900, 1'b0, 4);
    reset = 1'b1;
    #1;
    chk("midrst_feature", 32'(o_feature), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_no_output", 32'(o_valid), 32'd0);
    end
    b0[0] = 5; b1[0] = -7;
    do_frame("after_rst", 1, 0, 1'b1, 0);
    chk("after_rst_lit", 32'(o_feature), 32'({7'h47, 7'h05}));

    for (int f = 0; f < 25; f++) begin
      nb = int'($urandom_range(1, MAXB));
      ul = (nb < MAXB) ? 1'b1 : 1'($urandom_range(0, 1));
      sh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 31))
                                        : int'($urandom_range(0, 12));
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < nb; k++) begin
        b0[k] = int'($urandom_range(0, 4095)) - 2048;
        b1[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      do_frame("rand", nb, sh, ul, hold);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
